rename_regfile: RTL and testbench

- Architectural register file with per-register rename tags for the Tomasulo core.
- Holds committed values and, per register, the ROB tag of the youngest in-flight writer.
- Serves NUM_RD combinational source lookups to the issue unit; updated by issue (new tag), ROB commit (value, tag release) and flush (all tags dropped).
- Next generation of the single-pair register file: explicit tag-valid bit so ROB index 0 is a usable tag; parametrised register count, width and read-port count; optional commit-to-read bypass.

---
 rtl/rename_rf_pkg.sv | 26 ++
 rtl/rf_read_port.sv | 72 +++++++
 rtl/rename_regfile.sv | 104 ++++++++++
 tb/tb_rename_regfile.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_rf_pkg.sv
//-----------------------------------------------------------------------------
// rename_rf_pkg
//   Shared constants and helpers for the rename register file.
//   - reg_id_w(): width of a register id for a given register count
//   - DEF_*     : default parameter values
//   - ZERO_REG  : id of the hardwired-zero register
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

package rename_rf_pkg;

  localparam int DEF_XLEN      = 32;
  localparam int DEF_ROB_WIDTH = 4;
  localparam int DEF_NREG      = 32;
  localparam int DEF_NUM_RD    = 2;
  localparam int ZERO_REG      = 0;

  // A single-register file still needs a 1-bit id to keep port widths legal.
  function automatic int reg_id_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
//-----------------------------------------------------------------------------
// rf_read_port
//   One combinational source lookup into the rename register file.
//   Register 0 always reads as idle zero. With RENAME_RF_COMMIT_BYPASS_EN
//   defined, a commit that releases the looked-up register this cycle is
//   forwarded (busy=0, val=commit_val) so the consumer sees it immediately.
// Ports:
//   id                    : source register id
//   busy_vec/tag_arr/val_arr : registered state of every register
//   rdy, commit_*         : live commit bus (used by the bypass only)
//   busy/tag/val          : lookup result
// Optional macro: RENAME_RF_COMMIT_BYPASS_EN
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module rf_read_port
  import rename_rf_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int NREG      = DEF_NREG,
  parameter int ROB_WIDTH = DEF_ROB_WIDTH,
  parameter int REG_ID_W  = reg_id_w(DEF_NREG)
) (
  input  logic [REG_ID_W-1:0]  id,
  input  logic [NREG-1:0]      busy_vec,
  input  logic [ROB_WIDTH-1:0] tag_arr [NREG],
  input  logic [XLEN-1:0]      val_arr [NREG],
  input  logic                 rdy,
  input  logic                 commit_en,
  input  logic [REG_ID_W-1:0]  commit_rd,
  input  logic [ROB_WIDTH-1:0] commit_tag,
  input  logic [XLEN-1:0]      commit_val,
  output logic                 busy,
  output logic [ROB_WIDTH-1:0] tag,
  output logic [XLEN-1:0]      val
);

  logic is_zero;
  assign is_zero = (id == REG_ID_W'(ZERO_REG));

`ifdef RENAME_RF_COMMIT_BYPASS_EN
  // Forward only a commit that would actually release this register; a
  // stale-tag commit leaves the younger writer pending.
  logic bypass_hit;
  assign bypass_hit = rdy && commit_en && !is_zero && (commit_rd == id)
                      && busy_vec[id] && (tag_arr[id] == commit_tag);
`else
  logic bypass_hit;
  logic unused_commit_bus;
  assign bypass_hit        = 1'b0;
  assign unused_commit_bus = ^{rdy, commit_en, commit_rd, commit_tag, commit_val};
`endif

  always_comb begin
    busy = 1'b0;
    tag  = '0;
    val  = '0;
    if (!is_zero) begin
      busy = busy_vec[id];
      tag  = tag_arr[id];
      val  = val_arr[id];
      if (bypass_hit) begin
        busy = 1'b0;
        val  = commit_val;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rename_regfile.sv
//-----------------------------------------------------------------------------
// rename_regfile
//   Architectural register file with per-register rename tags. Each register
//   holds its committed value plus the ROB tag of its youngest in-flight
//   writer (valid when busy). Updated by issue, commit and flush; all state
//   freezes while rdy_in is low.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global stall), clr_in (flush)
//   issue_en/issue_rd/issue_tag       : rename a destination
//   rd_id -> rd_busy/rd_tag/rd_val    : NUM_RD combinational lookups
//   commit_en/commit_rd/commit_tag/commit_val : ROB commit
//   all_clear                         : no register has a pending tag
// Optional macro: RENAME_RF_COMMIT_BYPASS_EN (commit-to-read forwarding)
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module rename_regfile
  import rename_rf_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int NREG      = DEF_NREG,
  parameter int ROB_WIDTH = DEF_ROB_WIDTH,
  parameter int NUM_RD    = DEF_NUM_RD,
  localparam int REG_ID_W = reg_id_w(NREG)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         clr_in,
  input  logic                         issue_en,
  input  logic [REG_ID_W-1:0]          issue_rd,
  input  logic [ROB_WIDTH-1:0]         issue_tag,
  input  logic [NUM_RD*REG_ID_W-1:0]   rd_id,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic [NUM_RD*ROB_WIDTH-1:0]  rd_tag,
  output logic [NUM_RD*XLEN-1:0]       rd_val,
  input  logic                         commit_en,
  input  logic [REG_ID_W-1:0]          commit_rd,
  input  logic [ROB_WIDTH-1:0]         commit_tag,
  input  logic [XLEN-1:0]              commit_val,
  output logic                         all_clear
);

  logic [XLEN-1:0]      val_q  [NREG];
  logic [ROB_WIDTH-1:0] tag_q  [NREG];
  logic [NREG-1:0]      busy_q;

  // Register 0 is never written after reset, so it stays idle and zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
    end else if (rdy_in) begin
      for (int r = 1; r < NREG; r++) begin
        // The committed value lands even during a flush: it is architectural.
        if (commit_en && commit_rd == REG_ID_W'(r)) begin
          val_q[r] <= commit_val;
        end
        if (clr_in) begin
          busy_q[r] <= 1'b0;
        end else if (issue_en && issue_rd == REG_ID_W'(r)) begin
          // A new writer supersedes any same-cycle release.
          busy_q[r] <= 1'b1;
          tag_q[r]  <= issue_tag;
        end else if (commit_en && commit_rd == REG_ID_W'(r)
                     && busy_q[r] && tag_q[r] == commit_tag) begin
          // Only the youngest writer's commit frees the register.
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  assign all_clear = ~|busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
    rf_read_port #(
      .XLEN      (XLEN),
      .NREG      (NREG),
      .ROB_WIDTH (ROB_WIDTH),
      .REG_ID_W  (REG_ID_W)
    ) u_port (
      .id         (rd_id[i*REG_ID_W +: REG_ID_W]),
      .busy_vec   (busy_q),
      .tag_arr    (tag_q),
      .val_arr    (val_q),
      .rdy        (rdy_in),
      .commit_en  (commit_en),
      .commit_rd  (commit_rd),
      .commit_tag (commit_tag),
      .commit_val (commit_val),
      .busy       (rd_busy[i]),
      .tag        (rd_tag[i*ROB_WIDTH +: ROB_WIDTH]),
      .val        (rd_val[i*XLEN +: XLEN])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_rename_regfile.sv
//-----------------------------------------------------------------------------
// tb_rename_regfile
//   Self-checking bench for rename_regfile: directed scenarios followed by
//   randomized traffic compared against an array-based reference model.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_rename_regfile;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RW   = 4;
  localparam int NRD  = 2;
  localparam int IDW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            clr;
  logic            issue_en;
  logic [IDW-1:0]  issue_rd;
  logic [RW-1:0]   issue_tag;
  logic [NRD*IDW-1:0]  rd_id;
  logic [NRD-1:0]      rd_busy;
  logic [NRD*RW-1:0]   rd_tag;
  logic [NRD*XLEN-1:0] rd_val;
  logic            commit_en;
  logic [IDW-1:0]  commit_rd;
  logic [RW-1:0]   commit_tag;
  logic [XLEN-1:0] commit_val;
  logic            all_clear;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  bit            m_busy [NREG];
  bit [RW-1:0]   m_tag  [NREG];
  bit [XLEN-1:0] m_val  [NREG];

  always #5 clk = ~clk;

  rename_regfile #(.XLEN(XLEN), .NREG(NREG), .ROB_WIDTH(RW), .NUM_RD(NRD)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clr_in(clr),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rd_id(rd_id), .rd_busy(rd_busy), .rd_tag(rd_tag), .rd_val(rd_val),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_val(commit_val), .all_clear(all_clear)
  );

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_busy[r] = 0; m_tag[r] = '0; m_val[r] = '0;
    end
  endfunction

  // Edge update from the architectural rules.
  function automatic void model_update();
    bit release_ok;
    int cr, ir;
    if (!rdy) return;
    cr = int'(commit_rd);
    ir = int'(issue_rd);
    release_ok = 0;
    if (commit_en && cr != 0) begin
      release_ok = m_busy[cr] && (m_tag[cr] == commit_tag);
      m_val[cr] = commit_val;
    end
    if (clr) begin
      for (int r = 0; r < NREG; r++) m_busy[r] = 0;
    end else begin
      if (release_ok && !(issue_en && ir == cr)) m_busy[cr] = 0;
      if (issue_en && ir != 0) begin
        m_busy[ir] = 1;
        m_tag[ir]  = issue_tag;
      end
    end
  endfunction

  function automatic void model_read(input int id, output bit b,
                                     output bit [RW-1:0] t, output bit [XLEN-1:0] v);
    b = 0; t = '0; v = '0;
    if (id != 0) begin
      b = m_busy[id]; t = m_tag[id]; v = m_val[id];
`ifdef RENAME_RF_COMMIT_BYPASS_EN
      if (rdy && commit_en && int'(commit_rd) == id && m_busy[id] && m_tag[id] == commit_tag) begin
        b = 0; v = commit_val;
      end
`endif
    end
  endfunction

  function automatic bit model_all_clear();
    for (int r = 0; r < NREG; r++) if (m_busy[r]) return 0;
    return 1;
  endfunction

  task automatic idle();
    rdy = 1; clr = 0; issue_en = 0; commit_en = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_issue(input int rd, input int tg);
    issue_en = 1; issue_rd = IDW'(rd); issue_tag = RW'(tg);
  endtask

  task automatic do_commit(input int rd, input int tg, input logic [XLEN-1:0] v);
    commit_en = 1; commit_rd = IDW'(rd); commit_tag = RW'(tg); commit_val = v;
  endtask

  task automatic set_rd(input int p, input int id);
    rd_id[p*IDW +: IDW] = IDW'(id);
  endtask

  task automatic test_reset();
    idle(); do_issue(7, 3); tick();
    do_issue(9, 1); tick();
    idle();
    set_rd(0, 7); set_rd(1, 9);
    #2;
    rst = 1; model_reset();
    #1;
    vectors++;
    if (rd_busy !== 2'b00) begin
      miscompares++; $display("FAIL reset_busy got %b want %b", rd_busy, 2'b00);
    end
    vectors++;
    if (rd_val !== '0) begin
      miscompares++; $display("FAIL reset_val got %h want 0", rd_val);
    end
    vectors++;
    if (rd_tag !== '0) begin
      miscompares++; $display("FAIL reset_tag got %h want 0", rd_tag);
    end
    vectors++;
    if (all_clear !== 1'b1) begin
      miscompares++; $display("FAIL reset_all_clear got %b want 1", all_clear);
    end
    #1; rst = 0;
    tick();
  endtask

  task automatic test_tag_zero();
    idle(); do_issue(5, 0); tick();
    idle(); set_rd(0, 5); #2;
    vectors++;
    if (rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'h0) begin
      miscompares++; $display("FAIL tag0_issue got busy=%b tag=%h want busy=1 tag=0", rd_busy[0], rd_tag[3:0]);
    end
    vectors++;
    if (all_clear !== 1'b0) begin
      miscompares++; $display("FAIL tag0_all_clear_busy got %b want 0", all_clear);
    end
    do_commit(5, 0, 32'h1234); tick();
    idle(); #2;
    vectors++;
    if (rd_busy[0] !== 1'b0 || rd_val[31:0] !== 32'h1234) begin
      miscompares++; $display("FAIL tag0_commit got busy=%b val=%h want busy=0 val=1234", rd_busy[0], rd_val[31:0]);
    end
    vectors++;
    if (all_clear !== 1'b1) begin
      miscompares++; $display("FAIL tag0_all_clear got %b want 1", all_clear);
    end
  endtask

  task automatic test_rename_overwrite();
    idle(); do_issue(3, 2); tick();
    do_issue(3, 7); tick();
    idle(); do_commit(3, 2, 32'hAA); tick();
    idle(); set_rd(1, 3); #2;
    vectors++;
    if (rd_val[63:32] !== 32'hAA || rd_busy[1] !== 1'b1 || rd_tag[7:4] !== 4'h7) begin
      miscompares++; $display("FAIL overwrite_stale got val=%h busy=%b tag=%h want val=aa busy=1 tag=7",
                              rd_val[63:32], rd_busy[1], rd_tag[7:4]);
    end
    do_commit(3, 7, 32'hBB); tick();
    idle(); #2;
    vectors++;
    if (rd_val[63:32] !== 32'hBB || rd_busy[1] !== 1'b0) begin
      miscompares++; $display("FAIL overwrite_final got val=%h busy=%b want val=bb busy=0", rd_val[63:32], rd_busy[1]);
    end
  endtask

  task automatic test_collision();
    idle(); do_issue(8, 4); tick();
    idle(); do_commit(8, 4, 32'd9); do_issue(8, 6);
    set_rd(0, 8); #2;
    vectors++;
`ifdef RENAME_RF_COMMIT_BYPASS_EN
    if (rd_busy[0] !== 1'b0 || rd_val[31:0] !== 32'd9) begin
      miscompares++; $display("FAIL collision_read got busy=%b val=%h want busy=0 val=9", rd_busy[0], rd_val[31:0]);
    end
`else
    if (rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'h4) begin
      miscompares++; $display("FAIL collision_read got busy=%b tag=%h want busy=1 tag=4", rd_busy[0], rd_tag[3:0]);
    end
`endif
    tick();
    idle(); #2;
    vectors++;
    if (rd_val[31:0] !== 32'd9 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'h6) begin
      miscompares++; $display("FAIL collision_after got val=%h busy=%b tag=%h want val=9 busy=1 tag=6",
                              rd_val[31:0], rd_busy[0], rd_tag[3:0]);
    end
    do_commit(8, 6, 32'd10); tick();
    idle();
  endtask

  task automatic test_flush();
    idle(); do_issue(1, 1); tick();
    do_issue(2, 2); tick();
    do_issue(31, 3); tick();
    idle(); clr = 1; do_issue(4, 5); do_commit(1, 9, 32'h55); tick();
    idle(); set_rd(0, 1); set_rd(1, 4); #2;
    vectors++;
    if (rd_busy !== 2'b00 || rd_val[31:0] !== 32'h55) begin
      miscompares++; $display("FAIL flush_r1_r4 got busy=%b val=%h want busy=00 val=55", rd_busy, rd_val[31:0]);
    end
    set_rd(0, 2); set_rd(1, 31); #1;
    vectors++;
    if (rd_busy !== 2'b00) begin
      miscompares++; $display("FAIL flush_r2_r31 got busy=%b want 00", rd_busy);
    end
    vectors++;
    if (all_clear !== 1'b1) begin
      miscompares++; $display("FAIL flush_all_clear got %b want 1", all_clear);
    end
  endtask

  task automatic test_reg0_stall();
    idle(); do_issue(0, 3); do_commit(0, 0, 32'hFF); tick();
    idle(); set_rd(0, 0); #2;
    vectors++;
    if (rd_busy[0] !== 1'b0 || rd_val[31:0] !== 32'h0 || all_clear !== 1'b1) begin
      miscompares++; $display("FAIL reg0 got busy=%b val=%h all_clear=%b want 0 0 1", rd_busy[0], rd_val[31:0], all_clear);
    end
    // Stall: issue ignored
    rdy = 0; do_issue(6, 2); tick();
    tick();
    idle(); set_rd(0, 6); #2;
    vectors++;
    if (rd_busy[0] !== 1'b0 || all_clear !== 1'b1) begin
      miscompares++; $display("FAIL stall_issue got busy=%b all_clear=%b want 0 1", rd_busy[0], all_clear);
    end
    tick(); #2;
    vectors++;
    if (rd_busy[0] !== 1'b0) begin
      miscompares++; $display("FAIL stall_release got busy=%b want 0", rd_busy[0]);
    end
    // Stall also ignores flush and commit
    do_issue(10, 1); tick();
    idle(); rdy = 0; clr = 1; do_commit(10, 1, 32'h77); tick();
    idle(); set_rd(1, 10); #2;
    vectors++;
    if (rd_busy[1] !== 1'b1 || rd_val[63:32] !== 32'h0) begin
      miscompares++; $display("FAIL stall_flush got busy=%b val=%h want busy=1 val=0", rd_busy[1], rd_val[63:32]);
    end
    do_commit(10, 1, 32'h78); tick();
    idle();
  endtask

  task automatic test_random();
    bit eb; bit [RW-1:0] et; bit [XLEN-1:0] ev;
    int id, cr;
    for (int n = 0; n < 800; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 24) == 0);
      issue_en  = $urandom_range(0, 1) == 1;
      issue_rd  = IDW'($urandom_range(0, NREG-1));
      issue_tag = RW'($urandom);
      commit_en = $urandom_range(0, 2) != 0;
      cr = $urandom_range(0, 7);  // small range to force collisions
      if ($urandom_range(0, 3) == 0) cr = $urandom_range(0, NREG-1);
      commit_rd  = IDW'(cr);
      commit_tag = ($urandom_range(0, 3) != 0) ? m_tag[cr] : RW'($urandom);
      commit_val = $urandom;
      if ($urandom_range(0, 1) == 1) issue_rd = IDW'($urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) begin
        id = ($urandom_range(0, 3) == 0) ? cr : $urandom_range(0, 7);
        set_rd(p, id);
      end
      #2;
      for (int p = 0; p < NRD; p++) begin
        model_read(int'(rd_id[p*IDW +: IDW]), eb, et, ev);
        vectors++;
        if (rd_busy[p] !== eb || rd_val[p*XLEN +: XLEN] !== ev || (eb && rd_tag[p*RW +: RW] !== et)) begin
          miscompares++;
          $display("FAIL random_read port=%0d id=%0d got busy=%b tag=%h val=%h want busy=%b tag=%h val=%h",
                   p, rd_id[p*IDW +: IDW], rd_busy[p], rd_tag[p*RW +: RW], rd_val[p*XLEN +: XLEN], eb, et, ev);
        end
      end
      vectors++;
      if (all_clear !== model_all_clear()) begin
        miscompares++; $display("FAIL random_all_clear got %b want %b", all_clear, model_all_clear());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1; rdy = 1; clr = 0; issue_en = 0; issue_rd = '0; issue_tag = '0;
    commit_en = 0; commit_rd = '0; commit_tag = '0; commit_val = '0; rd_id = '0;
    model_reset();
    #12 rst = 0;
    tick();
    test_reset();
    test_tag_zero();
    test_rename_overwrite();
    test_collision();
    test_flush();
    test_reg0_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
